write_back_queue: RTL and testbench

- Parametrised next-generation write-back stage.
- Arbitrates ALU results and in-order, variable-latency load returns onto the single register-file write port.
- Holds the destinations of outstanding loads in a DEPTH-entry FIFO and exports a per-register pending mask for hazard detection.
- Sits between the execute/memory stages and the register file; all register-file write outputs are registered.

---
 rtl/write_back_queue.sv | 143 ++++++++++++++
 tb/tb_write_back_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_queue.sv
// Write-back stage: merges ALU results and in-order load returns onto one
// register-file write port, tracking outstanding load destinations in a FIFO.
`ifndef OP_WB_SIZE
`define OP_WB_SIZE 2
`endif
`ifndef WB_NONE
`define WB_NONE 2'd0
`endif
`ifndef WB_REGISTER
`define WB_REGISTER 2'd1
`endif
`ifndef WB_MEMORY
`define WB_MEMORY 2'd2
`endif

module write_back_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int GPR_WIDTH  = 5,
  parameter int DEPTH      = 4,
  parameter int ZERO_REG   = 1,
  localparam int NUM_REGS  = 2 ** GPR_WIDTH,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [`OP_WB_SIZE-1:0] in_writeback,
  input  logic [GPR_WIDTH-1:0]   in_destination,
  input  logic [DATA_WIDTH-1:0]  in_result,
  input  logic                   mem_valid,
  input  logic [DATA_WIDTH-1:0]  mem_data,
  output logic [GPR_WIDTH-1:0]   write_address,
  output logic [DATA_WIDTH-1:0]  write_data,
  output logic                   write_enable,
  output logic [NUM_REGS-1:0]    pending_mask,
  output logic [CNT_W-1:0]       pending_count,
  output logic                   protocol_error
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [GPR_WIDTH-1:0]  dest_q [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [GPR_WIDTH-1:0]  waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  perr_q, perr_d;

  logic                  is_reg, is_mem, q_empty, q_full;
  logic                  pop, push, reg_wr;
  logic [GPR_WIDTH-1:0]  head_dest;
  logic [PTR_W-1:0]      slot;

  always_comb begin
    is_reg    = (in_writeback == `WB_REGISTER);
    is_mem    = (in_writeback == `WB_MEMORY);
    q_empty   = (count_q == '0);
    q_full    = (count_q == FULL_CNT);
    pop       = mem_valid && !q_empty;
    head_dest = dest_q[head_q];
    // A returning load cannot stall, so it wins the port; a full queue may
    // still take a new load in the cycle its head pops.
    if (is_reg)      in_ready = !mem_valid;
    else if (is_mem) in_ready = !q_full || pop;
    else             in_ready = 1'b1;
    push   = in_valid && in_ready && is_mem;
    reg_wr = in_valid && in_ready && is_reg;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    perr_d  = perr_q | (mem_valid & q_empty);

    if (pop)  head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
    if (push) tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (pop) begin
      waddr_d = head_dest;
      wdata_d = mem_data;
      we_d    = !((ZERO_REG != 0) && (head_dest == '0));
    end else if (reg_wr) begin
      waddr_d = in_destination;
      wdata_d = in_result;
      we_d    = !((ZERO_REG != 0) && (in_destination == '0));
    end
  end

  always_comb begin
    pending_mask = '0;
    slot         = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count_q) begin
        slot = PTR_W'((int'(head_q) + k) % DEPTH);
        pending_mask[dest_q[slot]] = 1'b1;
      end
    end
    if (ZERO_REG != 0) pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) dest_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (push) dest_q[tail_q] <= in_destination;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      perr_q  <= perr_d;
    end
  end

  assign write_address  = waddr_q;
  assign write_data     = wdata_q;
  assign write_enable   = we_q;
  assign pending_count  = count_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_write_back_queue.sv
// Directed bench for write_back_queue with default parameters (DEPTH=4, ZERO_REG=1).
`ifndef OP_WB_SIZE
`define OP_WB_SIZE 2
`endif
`ifndef WB_NONE
`define WB_NONE 2'd0
`endif
`ifndef WB_REGISTER
`define WB_REGISTER 2'd1
`endif
`ifndef WB_MEMORY
`define WB_MEMORY 2'd2
`endif

module tb_write_back_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_writeback;
  logic [4:0]  in_destination;
  logic [31:0] in_result;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] pending_mask;
  logic [2:0]  pending_count;
  logic        protocol_error;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int exp_addr;

  always #5 clk = ~clk;

  write_back_queue dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_writeback   (in_writeback),
    .in_destination (in_destination),
    .in_result      (in_result),
    .mem_valid      (mem_valid),
    .mem_data       (mem_data),
    .write_address  (write_address),
    .write_data     (write_data),
    .write_enable   (write_enable),
    .pending_mask   (pending_mask),
    .pending_count  (pending_count),
    .protocol_error (protocol_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drv(input logic v, input logic [1:0] wb, input logic [4:0] d,
                     input logic [31:0] r, input logic mv, input logic [31:0] md);
    in_valid       = v;
    in_writeback   = wb;
    in_destination = d;
    in_result      = r;
    mem_valid      = mv;
    mem_data       = md;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, `WB_NONE, 5'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #12;
    check("rst_we", write_enable, 0);
    check("rst_addr", write_address, 0);
    check("rst_data", write_data, 0);
    check("rst_count", pending_count, 0);
    check("rst_mask", pending_mask, 0);
    check("rst_perr", protocol_error, 0);
    @(negedge clk);
    reset = 1'b0;

    // plain register write
    drv(1'b1, `WB_REGISTER, 5'd7, 32'hDEADBEEF, 1'b0, 32'd0);
    check("reg_ready", in_ready, 1);
    tick();
    check("reg_we", write_enable, 1);
    check("reg_addr", write_address, 7);
    check("reg_data", write_data, 32'hDEADBEEF);
    idle();
    tick();
    check("reg_we_off", write_enable, 0);
    check("reg_addr_hold", write_address, 7);

    // three loads, two to the same register
    drv(1'b1, `WB_MEMORY, 5'd3, 32'd0, 1'b0, 32'd0); tick();
    check("ld_no_write", write_enable, 0);
    drv(1'b1, `WB_MEMORY, 5'd5, 32'd0, 1'b0, 32'd0); tick();
    drv(1'b1, `WB_MEMORY, 5'd3, 32'd0, 1'b0, 32'd0); tick();
    check("ld_count3", pending_count, 3);
    check("ld_mask3", pending_mask, 32'h28);
    drv(1'b0, `WB_NONE, 5'd0, 32'd0, 1'b1, 32'h11); tick();
    check("ld1_we", write_enable, 1);
    check("ld1_addr", write_address, 3);
    check("ld1_data", write_data, 32'h11);
    check("ld1_mask", pending_mask, 32'h28);
    drv(1'b0, `WB_NONE, 5'd0, 32'd0, 1'b1, 32'h22); tick();
    check("ld2_addr", write_address, 5);
    check("ld2_data", write_data, 32'h22);
    check("ld2_mask", pending_mask, 32'h08);
    drv(1'b0, `WB_NONE, 5'd0, 32'd0, 1'b1, 32'h33); tick();
    check("ld3_addr", write_address, 3);
    check("ld3_data", write_data, 32'h33);
    check("ld3_mask", pending_mask, 0);
    check("ld3_count", pending_count, 0);
    idle(); tick();
    check("ld_we_off", write_enable, 0);

    // ALU result collides with a load return
    drv(1'b1, `WB_MEMORY, 5'd4, 32'd0, 1'b0, 32'd0); tick();
    drv(1'b1, `WB_REGISTER, 5'd9, 32'hA5A5, 1'b1, 32'h44);
    check("cf_ready0", in_ready, 0);
    tick();
    check("cf_ld_addr", write_address, 4);
    check("cf_ld_data", write_data, 32'h44);
    drv(1'b1, `WB_REGISTER, 5'd9, 32'hA5A5, 1'b0, 32'd0);
    check("cf_ready1", in_ready, 1);
    tick();
    check("cf_reg_we", write_enable, 1);
    check("cf_reg_addr", write_address, 9);
    check("cf_reg_data", write_data, 32'hA5A5);
    idle();

    // fill the queue, then stall, then push+pop through a wrap
    for (int k = 1; k <= 4; k++) begin
      drv(1'b1, `WB_MEMORY, 5'(k), 32'd0, 1'b0, 32'd0); tick();
      exp_q.push_back(k);
    end
    check("full_count", pending_count, 4);
    check("full_mask", pending_mask, 32'h1E);
    drv(1'b1, `WB_MEMORY, 5'd6, 32'd0, 1'b0, 32'd0);
    check("full_stall", in_ready, 0);
    tick();
    check("full_stall_count", pending_count, 4);
    for (int k = 0; k < 10; k++) begin
      drv(1'b1, `WB_MEMORY, 5'(6 + k), 32'd0, 1'b1, 32'h100 + k);
      check("wrap_ready", in_ready, 1);
      tick();
      exp_addr = exp_q.pop_front();
      exp_q.push_back(6 + k);
      check("wrap_addr", write_address, exp_addr);
      check("wrap_data", write_data, 32'h100 + k);
      check("wrap_count", pending_count, 4);
    end
    check("wrap_mask", pending_mask, 32'h0000_F000);
    for (int k = 0; k < 4; k++) begin
      drv(1'b0, `WB_NONE, 5'd0, 32'd0, 1'b1, 32'h200 + k); tick();
      exp_addr = exp_q.pop_front();
      check("drain_addr", write_address, exp_addr);
      check("drain_we", write_enable, 1);
    end
    check("drain_count", pending_count, 0);
    check("drain_mask", pending_mask, 0);
    idle();

    // register 0 is never written nor marked pending
    drv(1'b1, `WB_REGISTER, 5'd0, 32'h55, 1'b0, 32'd0);
    check("z_ready", in_ready, 1);
    tick();
    check("z_reg_we", write_enable, 0);
    drv(1'b1, `WB_MEMORY, 5'd0, 32'd0, 1'b0, 32'd0); tick();
    check("z_ld_count", pending_count, 1);
    check("z_ld_mask", pending_mask, 0);
    drv(1'b0, `WB_NONE, 5'd0, 32'd0, 1'b1, 32'h66); tick();
    check("z_ld_we", write_enable, 0);
    check("z_ld_count0", pending_count, 0);
    check("z_perr", protocol_error, 0);
    idle();

    // reset mid-stream, then a stray load return
    for (int k = 1; k <= 3; k++) begin
      drv(1'b1, `WB_MEMORY, 5'(k), 32'd0, 1'b0, 32'd0); tick();
    end
    drv(1'b1, `WB_REGISTER, 5'd8, 32'h77, 1'b0, 32'd0); tick();
    check("pre_rst_we", write_enable, 1);
    check("pre_rst_count", pending_count, 3);
    idle();
    reset = 1'b1;
    #1;
    check("mid_rst_we", write_enable, 0);
    check("mid_rst_addr", write_address, 0);
    check("mid_rst_data", write_data, 0);
    check("mid_rst_count", pending_count, 0);
    check("mid_rst_mask", pending_mask, 0);
    @(negedge clk);
    reset = 1'b0;
    drv(1'b0, `WB_NONE, 5'd0, 32'd0, 1'b1, 32'h99); tick();
    check("stray_perr", protocol_error, 1);
    check("stray_we", write_enable, 0);
    check("stray_count", pending_count, 0);
    idle(); tick();
    check("perr_sticky", protocol_error, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
